mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- MEM-stage load/store unit of the five-stage core.
- Consumes the EX/MEM pipeline-register outputs and runs one request/acknowledge transaction per load or store on the data bus.
- Stalls the pipeline until the transaction completes, then presents write-back values to the MEM/WB register.
- Non-memory instructions pass through combinationally with no added latency.

Parameters:
OP_LOAD, 7'b0000011, aluop value identifying loads
OP_STORE, 7'b0100011, aluop value identifying stores
TIMEOUT_CYCLES, 256, BUSY cycles without dbus_ack before the access is aborted

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  6  pipeline stall vector; bit 4 holds MEM/WB
- mem_reg_waddr  in  32  destination register from EX/MEM
- mem_reg_we  in  1  register write enable from EX/MEM
- mem_reg_data  in  32  ALU result from EX/MEM
- mem_csr_waddr  in  32  CSR address from EX/MEM
- mem_csr_we  in  1  CSR write enable from EX/MEM
- mem_csr_data  in  32  CSR data from EX/MEM
- mem_mem_addr  in  32  effective byte address
- mem_aluop  in  7  opcode
- mem_mem_data  in  32  store data (rs2)
- mem_sel  in  3  funct3 (width/sign)
- wb_reg_waddr  out  32  to MEM/WB
- wb_reg_we  out  1  to MEM/WB
- wb_reg_data  out  32  to MEM/WB
- wb_csr_waddr  out  32  to MEM/WB
- wb_csr_we  out  1  to MEM/WB
- wb_csr_data  out  32  to MEM/WB
- stallreq_mem  out  1  stall request to pipeline control
- mem_exc  out  1  misaligned/illegal/timeout access
- dbus_req  out  1  bus request, registered
- dbus_we  out  1  bus write
- dbus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dbus_wdata  out  32  lane-replicated store data
- dbus_be  out  4  byte enables
- dbus_ack  in  1  bus acknowledge, sampled at posedge
- dbus_rdata  in  32  read data, valid with ack

Behaviour:
- While rst is high, every output is 0, FSM→IDLE, timeout counter and load buffer are 0.
- Memop = aluop is OP_LOAD or OP_STORE.
- Legal sel values:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000 SB, 001 SH, 010 SW
- Misaligned access: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0. Illegal sel is treated the same way.
- Misaligned or illegal access:
  - no bus request, no stall
  - mem_exc=1 combinationally
  - wb_reg_we=0, wb_csr_we=0
- Non-memop: all wb_* = corresponding mem_* inputs combinationally; stallreq_mem=0; FSM remains IDLE.
- FSM states IDLE, BUSY, DONE:
  - IDLE: a legal memop gives stallreq_mem=1 combinationally. Next edge: →BUSY, dbus_req←1, address/we/wdata/be captured into registers, counter←0.
  - BUSY:
    - dbus_req=1; bus outputs held stable; stallreq_mem=1; counter increments.
    - On ack: load buffer←extracted dbus_rdata, dbus_req←0, →DONE.
    - If counter reaches TIMEOUT_CYCLES-1 without ack: dbus_req←0, exc flag←1, →DONE.
  - DONE:
    - stallreq_mem=0.
    - Loads: wb_reg_data = load buffer.
    - Stores: wb_reg_we=0.
    - Timeout: mem_exc=1, wb_reg_we=0.
    - Stays in DONE while stall[4]=1; →IDLE (exc flag cleared) when stall[4]=0.
- Latency: zero-wait bus gives 3 cycles in MEM; each ack wait cycle adds 1.
- dbus_ack in IDLE or DONE is ignored. At most one transaction per instruction.
- Store steering:
  - SB: wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0]
  - SH: wdata={2{d[15:0]}}, be=addr[1]?4'b1100:4'b0011
  - SW: wdata=d, be=4'b1111
- Load extract: byte/halfword selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
- Loads drive dbus_be=4'b1111 and dbus_we=0.
- rst in BUSY: dbus_req=0 after that edge. The abandoned transaction is the bus slave's responsibility (it is reset by the same rst).

Decomposition:
- Package riscv_mem_pkg holds:
  - OP_LOAD and OP_STORE
  - the funct3 codes LB, LH, LW, LBU, LHU, SB, SH, SW
  - the FSM state encoding
- Sub-module lsu_align (combinational) performs store lane steering/byte enables, load extraction/extension, and misalign/illegal detection.

Test Plan:
- LW addr 0x100, ack after 2 wait cycles, rdata 0xDEADBEEF -> stallreq_mem high 4 cycles; in DONE wb_reg_data=0xDEADBEEF, wb_reg_we=1.
- LB addr 0x103, rdata 0x80FF0011, zero-wait ack -> wb_reg_data=0xFFFFFF80. LBU same address -> 0x00000080. dbus_addr=0x100 in both cases.
- SH addr 0x202, data 0x1234ABCD -> dbus_we=1, dbus_wdata=0xABCDABCD, dbus_be=4'b1100; in DONE wb_reg_we=0.
- LW addr 0x101 -> dbus_req stays 0, mem_exc=1, stallreq_mem=0, wb_reg_we=0.
- LW with ack never asserted -> dbus_req drops after 256 BUSY cycles; mem_exc=1 in DONE; stall releases.
- rst pulsed while in BUSY, then aluop 0110011 with reg_data 0x5 -> dbus_req=0 after the edge; afterwards wb_reg_data=0x5, no stall.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared opcodes, funct3 codes, FSM encoding and bus payload type for the MEM-stage LSU.
package riscv_mem_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dbus_txn_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational store lane steering, load extraction/extension and misalign/illegal detection.
module lsu_align
    import riscv_mem_pkg::*;
(
    input  logic        is_load,
    input  logic        is_store,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  sel,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data,
    output logic        bad
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr_lo)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        wdata     = store_data;
        be        = 4'b1111;
        load_data = rdata;
        bad       = 1'b0;
        if (is_store) begin
            case (sel)
                SB: begin
                    wdata = {4{store_data[7:0]}};
                    be    = 4'b0001 << addr_lo;
                end
                SH: begin
                    wdata = {2{store_data[15:0]}};
                    be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                    bad   = addr_lo[0];
                end
                SW:      bad = |addr_lo;
                default: bad = 1'b1;
            endcase
        end else if (is_load) begin
            case (sel)
                LB:  load_data = {{24{lane_b[7]}}, lane_b};
                LBU: load_data = {24'd0, lane_b};
                LH: begin
                    load_data = {{16{lane_h[15]}}, lane_h};
                    bad       = addr_lo[0];
                end
                LHU: begin
                    load_data = {16'd0, lane_h};
                    bad       = addr_lo[0];
                end
                LW:      bad = |addr_lo;
                default: bad = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one req/ack bus transaction per load/store, stalling until done.
module mem_lsu
    import riscv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [31:0] mem_reg_waddr,
    input  logic        mem_reg_we,
    input  logic [31:0] mem_reg_data,
    input  logic [31:0] mem_csr_waddr,
    input  logic        mem_csr_we,
    input  logic [31:0] mem_csr_data,
    input  logic [31:0] mem_mem_addr,
    input  logic [6:0]  mem_aluop,
    input  logic [31:0] mem_mem_data,
    input  logic [2:0]  mem_sel,
    output logic [31:0] wb_reg_waddr,
    output logic        wb_reg_we,
    output logic [31:0] wb_reg_data,
    output logic [31:0] wb_csr_waddr,
    output logic        wb_csr_we,
    output logic [31:0] wb_csr_data,
    output logic        stallreq_mem,
    output logic        mem_exc,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q, state_d;
    dbus_txn_t   txn_q;
    logic        req_q, exc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0] load_buf_q;

    logic        is_load, is_store, memop, bad, timeout;
    logic [31:0] st_wdata, ld_data;
    logic [3:0]  st_be;
    logic        unused_stall;

    assign is_load      = (mem_aluop == OP_LOAD);
    assign is_store     = (mem_aluop == OP_STORE);
    assign memop        = is_load | is_store;
    assign timeout      = (cnt_q == CNT_LAST);
    assign unused_stall = ^{stall[5], stall[3:0]};

    lsu_align u_align (
        .is_load    (is_load),
        .is_store   (is_store),
        .addr_lo    (mem_mem_addr[1:0]),
        .sel        (mem_sel),
        .store_data (mem_mem_data),
        .rdata      (dbus_rdata),
        .wdata      (st_wdata),
        .be         (st_be),
        .load_data  (ld_data),
        .bad        (bad)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Bus request capture, timeout counter, load buffer and exception flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            txn_q      <= '0;
            req_q      <= 1'b0;
            exc_q      <= 1'b0;
            cnt_q      <= '0;
            load_buf_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (memop && !bad) begin
                        req_q       <= 1'b1;
                        txn_q.we    <= is_store;
                        txn_q.addr  <= {mem_mem_addr[31:2], 2'b00};
                        txn_q.wdata <= st_wdata;
                        txn_q.be    <= st_be;
                        cnt_q       <= '0;
                    end
                end
                ST_BUSY: begin
                    if (dbus_ack) begin
                        load_buf_q <= ld_data;
                        req_q      <= 1'b0;
                    end else if (timeout) begin
                        req_q <= 1'b0;
                        exc_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!stall[4]) exc_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Next state plus write-back, stall and exception outputs.
    always_comb begin
        state_d      = state_q;
        stallreq_mem = 1'b0;
        mem_exc      = 1'b0;
        wb_reg_waddr = mem_reg_waddr;
        wb_reg_we    = mem_reg_we;
        wb_reg_data  = mem_reg_data;
        wb_csr_waddr = mem_csr_waddr;
        wb_csr_we    = mem_csr_we;
        wb_csr_data  = mem_csr_data;

        if (memop) begin
            if (is_load)  wb_reg_data = load_buf_q;
            if (is_store) wb_reg_we   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (memop) begin
                    if (bad) begin
                        mem_exc   = 1'b1;
                        wb_reg_we = 1'b0;
                        wb_csr_we = 1'b0;
                    end else begin
                        stallreq_mem = 1'b1;
                        state_d      = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                stallreq_mem = 1'b1;
                if (dbus_ack || timeout) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (exc_q) begin
                    mem_exc   = 1'b1;
                    wb_reg_we = 1'b0;
                end
                if (!stall[4]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (rst) begin
            state_d      = ST_IDLE;
            stallreq_mem = 1'b0;
            mem_exc      = 1'b0;
            wb_reg_waddr = '0;
            wb_reg_we    = 1'b0;
            wb_reg_data  = '0;
            wb_csr_waddr = '0;
            wb_csr_we    = 1'b0;
            wb_csr_data  = '0;
        end
    end

    assign dbus_req   = req_q;
    assign dbus_we    = txn_q.we;
    assign dbus_addr  = txn_q.addr;
    assign dbus_wdata = txn_q.wdata;
    assign dbus_be    = txn_q.be;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed table, hand sequences and randomized accesses vs a reference model.
module tb_mem_lsu;

    localparam logic [6:0] LD_OP   = 7'b0000011;
    localparam logic [6:0] ST_OP   = 7'b0100011;
    localparam logic [6:0] ALU_OP  = 7'b0110011;
    localparam int         TIMEOUT = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [31:0] mem_reg_waddr, mem_reg_data, mem_csr_waddr, mem_csr_data;
    logic        mem_reg_we, mem_csr_we;
    logic [31:0] mem_mem_addr, mem_mem_data;
    logic [6:0]  mem_aluop;
    logic [2:0]  mem_sel;
    logic [31:0] wb_reg_waddr, wb_reg_data, wb_csr_waddr, wb_csr_data;
    logic        wb_reg_we, wb_csr_we;
    logic        stallreq_mem, mem_exc;
    logic        dbus_req, dbus_we, dbus_ack;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk(clk), .rst(rst), .stall(stall),
        .mem_reg_waddr(mem_reg_waddr), .mem_reg_we(mem_reg_we), .mem_reg_data(mem_reg_data),
        .mem_csr_waddr(mem_csr_waddr), .mem_csr_we(mem_csr_we), .mem_csr_data(mem_csr_data),
        .mem_mem_addr(mem_mem_addr), .mem_aluop(mem_aluop), .mem_mem_data(mem_mem_data),
        .mem_sel(mem_sel),
        .wb_reg_waddr(wb_reg_waddr), .wb_reg_we(wb_reg_we), .wb_reg_data(wb_reg_data),
        .wb_csr_waddr(wb_csr_waddr), .wb_csr_we(wb_csr_we), .wb_csr_data(wb_csr_data),
        .stallreq_mem(stallreq_mem), .mem_exc(mem_exc),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_be(dbus_be),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          wait_n;    // ack wait cycles; -1 = never acknowledge
        int          hold;      // DONE cycles held by stall[4]
        logic        bus;       // a bus transaction is expected
        logic        exp_exc;
        logic        exp_we;
        logic [31:0] exp_data;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] sel, input logic [31:0] addr,
                                input logic [31:0] sdata, input logic [31:0] rdata, input int wait_n,
                                input int hold, input logic bus, input logic exc, input logic we,
                                input logic [31:0] data, input logic [31:0] wdata, input logic [3:0] be);
        vec_t v;
        v.op = op; v.sel = sel; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
        v.wait_n = wait_n; v.hold = hold; v.bus = bus; v.exp_exc = exc; v.exp_we = we;
        v.exp_data = data; v.exp_wdata = wdata; v.exp_be = be;
        return v;
    endfunction

    // Reference model: access size from funct3, alignment by modulo, lanes by shifts/multiplies.
    function automatic vec_t model(input logic [6:0] op, input logic [2:0] sel, input logic [31:0] addr,
                                   input logic [31:0] sdata, input logic [31:0] rdata, input int wait_n,
                                   input int hold);
        vec_t v;
        int s, size, off;
        logic legal;
        logic [31:0] w, d;
        s    = int'(sel);
        size = 1 << (s % 4);
        off  = int'(addr % 4);
        if (op == LD_OP) legal = (s == 0 || s == 1 || s == 2 || s == 4 || s == 5);
        else             legal = (s <= 2);
        if (legal && (off % size) != 0) legal = 1'b0;
        w = rdata >> (8 * off);
        if (size == 1)      d = w % 256;
        else if (size == 2) d = w % 65536;
        else                d = w;
        if (s == 0 && d >= 128)   d = d - 256;
        if (s == 1 && d >= 32768) d = d - 65536;
        v = mk(op, sel, addr, sdata, rdata, wait_n, hold, legal, !legal || wait_n < 0,
               legal && wait_n >= 0 && op == LD_OP, d, sdata, 4'hF);
        if (op == ST_OP) begin
            if (size == 1)      v.exp_wdata = (sdata % 256) * 32'h01010101;
            else if (size == 2) v.exp_wdata = (sdata % 65536) * 32'h00010001;
            v.exp_be = 4'(((1 << size) - 1) << off);
        end
        return v;
    endfunction

    task automatic set_alu(input logic [31:0] data);
        mem_aluop     = ALU_OP;
        mem_reg_data  = data;
        mem_reg_we    = 1'b1;
        mem_reg_waddr = 32'd7;
    endtask

    // Runs one instruction from posedge+1 to posedge+1 after it has left MEM.
    task automatic run_access(input vec_t v, input string tag);
        int busy, stall_cnt;
        logic done, csr_we;
        csr_we        = 1'($urandom);
        mem_aluop     = v.op;
        mem_sel       = v.sel;
        mem_mem_addr  = v.addr;
        mem_mem_data  = v.sdata;
        mem_reg_we    = 1'b1;
        mem_reg_data  = $urandom;
        mem_reg_waddr = $urandom;
        mem_csr_we    = csr_we;
        mem_csr_waddr = $urandom;
        mem_csr_data  = $urandom;
        stall         = 6'd0;
        dbus_ack      = 1'b0;
        @(negedge clk);
        if (!v.bus) begin
            chk({tag, " bad_req"},   32'(dbus_req), 32'd0);
            chk({tag, " bad_exc"},   32'(mem_exc), 32'd1);
            chk({tag, " bad_stall"}, 32'(stallreq_mem), 32'd0);
            chk({tag, " bad_we"},    32'(wb_reg_we), 32'd0);
            chk({tag, " bad_csrwe"}, 32'(wb_csr_we), 32'd0);
            @(posedge clk); #1;
        end else begin
            chk({tag, " idle_stall"}, 32'(stallreq_mem), 32'd1);
            chk({tag, " idle_exc"},   32'(mem_exc), 32'd0);
            @(posedge clk); #1;
            busy = 0; stall_cnt = 1; done = 1'b0;
            for (int g = 0; g < 400 && !done; g++) begin
                @(negedge clk);
                if (!dbus_req) done = 1'b1;
                else begin
                    if (busy == 0) begin
                        chk({tag, " dbus_addr"}, dbus_addr, v.addr & ~32'h3);
                        chk({tag, " dbus_we"},   32'(dbus_we), 32'(v.op == ST_OP));
                        chk({tag, " dbus_be"},   32'(dbus_be), 32'(v.exp_be));
                        if (v.op == ST_OP) chk({tag, " dbus_wdata"}, dbus_wdata, v.exp_wdata);
                    end
                    if (stallreq_mem) stall_cnt++;
                    if (busy == v.wait_n) begin
                        dbus_ack   = 1'b1;
                        dbus_rdata = v.rdata;
                    end
                    @(posedge clk); #1;
                    dbus_ack   = 1'b0;
                    dbus_rdata = $urandom;
                    busy++;
                end
            end
            if (!done) begin
                n_checks++; n_fail++;
                $display("FAIL %s busy_bound: dbus_req still high after 400 cycles", tag);
            end
            chk({tag, " busy_cycles"}, 32'(busy), 32'(v.wait_n >= 0 ? v.wait_n + 1 : TIMEOUT));
            chk({tag, " stall_cycles"}, 32'(stall_cnt), 32'(1 + (v.wait_n >= 0 ? v.wait_n + 1 : TIMEOUT)));
            for (int h = 0; h <= v.hold; h++) begin
                if (h > 0) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                    chk({tag, " hold_req"}, 32'(dbus_req), 32'd0);
                end
                chk({tag, " done_stall"}, 32'(stallreq_mem), 32'd0);
                chk({tag, " done_exc"},   32'(mem_exc), 32'(v.exp_exc));
                chk({tag, " done_we"},    32'(wb_reg_we), 32'(v.exp_we));
                chk({tag, " done_csrwe"}, 32'(wb_csr_we), 32'(csr_we));
                if (v.exp_we) chk({tag, " done_data"}, wb_reg_data, v.exp_data);
                if (h < v.hold) begin
                    stall    = 6'b010000;
                    dbus_ack = 1'b1;
                end
            end
            stall    = 6'd0;
            dbus_ack = 1'b0;
            @(posedge clk); #1;
        end
        set_alu($urandom);
        @(negedge clk);
        chk({tag, " after_req"},   32'(dbus_req), 32'd0);
        chk({tag, " after_stall"}, 32'(stallreq_mem), 32'd0);
        chk({tag, " after_exc"},   32'(mem_exc), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[14];
        vec_t rv;
        logic [31:0] d;

        tbl[0]  = mk(LD_OP, 3'd2, 32'h100, 0, 32'hDEADBEEF, 2, 0, 1, 0, 1, 32'hDEADBEEF, 0, 4'hF);
        tbl[1]  = mk(LD_OP, 3'd0, 32'h103, 0, 32'h80FF0011, 0, 0, 1, 0, 1, 32'hFFFFFF80, 0, 4'hF);
        tbl[2]  = mk(LD_OP, 3'd4, 32'h103, 0, 32'h80FF0011, 0, 0, 1, 0, 1, 32'h00000080, 0, 4'hF);
        tbl[3]  = mk(ST_OP, 3'd1, 32'h202, 32'h1234ABCD, 0, 0, 0, 1, 0, 0, 0, 32'hABCDABCD, 4'hC);
        tbl[4]  = mk(LD_OP, 3'd2, 32'h101, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'h0);
        tbl[5]  = mk(LD_OP, 3'd1, 32'h102, 0, 32'h80011234, 1, 1, 1, 0, 1, 32'hFFFF8001, 0, 4'hF);
        tbl[6]  = mk(LD_OP, 3'd5, 32'h102, 0, 32'h80011234, 0, 2, 1, 0, 1, 32'h00008001, 0, 4'hF);
        tbl[7]  = mk(ST_OP, 3'd2, 32'h300, 32'hCAFEF00D, 0, 1, 0, 1, 0, 0, 0, 32'hCAFEF00D, 4'hF);
        tbl[8]  = mk(ST_OP, 3'd0, 32'h301, 32'h000000A5, 0, 3, 0, 1, 0, 0, 0, 32'hA5A5A5A5, 4'h2);
        tbl[9]  = mk(LD_OP, 3'd3, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'h0);
        tbl[10] = mk(ST_OP, 3'd1, 32'h203, 32'h1, 0, 0, 0, 0, 1, 0, 0, 0, 4'h0);
        tbl[11] = mk(ST_OP, 3'd4, 32'h200, 32'h1, 0, 0, 0, 0, 1, 0, 0, 0, 4'h0);
        tbl[12] = mk(LD_OP, 3'd0, 32'h101, 0, 32'h00007F00, 0, 0, 1, 0, 1, 32'h0000007F, 0, 4'hF);
        tbl[13] = mk(LD_OP, 3'd2, 32'h400, 0, 0, -1, 1, 1, 1, 0, 0, 0, 4'hF);

        rst = 1'b1; stall = 6'd0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
        mem_sel = 3'd0; mem_mem_addr = 32'h0; mem_mem_data = 32'h0;
        mem_csr_we = 1'b1; mem_csr_waddr = 32'h300; mem_csr_data = 32'h1234;
        set_alu(32'h55AA55AA);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_data",  wb_reg_data, 32'd0);
        chk("rst_wb_we",    32'(wb_reg_we), 32'd0);
        chk("rst_csr_we",   32'(wb_csr_we), 32'd0);
        chk("rst_csr_data", wb_csr_data, 32'd0);
        chk("rst_stall",    32'(stallreq_mem), 32'd0);
        chk("rst_exc",      32'(mem_exc), 32'd0);
        chk("rst_req",      32'(dbus_req), 32'd0);
        chk("rst_addr",     dbus_addr, 32'd0);
        chk("rst_be",       32'(dbus_be), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Non-memory pass-through
        for (int i = 0; i < 5; i++) begin
            mem_aluop     = 7'($urandom_range(0, 127));
            if (mem_aluop == LD_OP || mem_aluop == ST_OP) mem_aluop = ALU_OP;
            mem_reg_data  = $urandom; mem_reg_waddr = $urandom; mem_reg_we = 1'($urandom);
            mem_csr_data  = $urandom; mem_csr_waddr = $urandom; mem_csr_we = 1'($urandom);
            mem_mem_addr  = $urandom; mem_sel = 3'($urandom);
            @(negedge clk);
            chk("pass_reg_data",  wb_reg_data, mem_reg_data);
            chk("pass_reg_waddr", wb_reg_waddr, mem_reg_waddr);
            chk("pass_reg_we",    32'(wb_reg_we), 32'(mem_reg_we));
            chk("pass_csr",       {wb_csr_data ^ wb_csr_waddr}, {mem_csr_data ^ mem_csr_waddr});
            chk("pass_csr_we",    32'(wb_csr_we), 32'(mem_csr_we));
            chk("pass_stall",     32'(stallreq_mem), 32'd0);
            chk("pass_req",       32'(dbus_req), 32'd0);
            @(posedge clk); #1;
        end

        // Directed table
        for (int i = 0; i < 14; i++) run_access(tbl[i], $sformatf("vec%0d", i));

        // Reset while BUSY, then an ALU op passes through
        mem_aluop = LD_OP; mem_sel = 3'd2; mem_mem_addr = 32'h500; mem_reg_we = 1'b1;
        @(negedge clk);
        chk("rstbusy_idle_stall", 32'(stallreq_mem), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstbusy_req_before", 32'(dbus_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstbusy_stall_in_rst", 32'(stallreq_mem), 32'd0);
        chk("rstbusy_data_in_rst",  wb_reg_data, 32'd0);
        @(posedge clk); #1;
        chk("rstbusy_req_after", 32'(dbus_req), 32'd0);
        rst = 1'b0;
        set_alu(32'h5);
        @(negedge clk);
        chk("rstbusy_pass_data",  wb_reg_data, 32'h5);
        chk("rstbusy_pass_stall", 32'(stallreq_mem), 32'd0);
        chk("rstbusy_pass_req",   32'(dbus_req), 32'd0);
        @(posedge clk); #1;

        // Randomized accesses against the reference model
        for (int i = 0; i < 40; i++) begin
            d  = $urandom;
            rv = model($urandom_range(0, 1) ? LD_OP : ST_OP, 3'($urandom_range(0, 7)), d,
                       $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 1));
            run_access(rv, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
